// File: rtl/gc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gc_pkg : shared widths, frame type and word-extraction helper for the
//          garbled-table serializer.   rev 1.0
// ---------------------------------------------------------------------------
package gc_pkg;

    localparam int LABEL_W         = 80;
    localparam int GID_W           = 64;
    localparam int TX_W            = 32;
    localparam int WORDS_PER_FRAME = 10;
    localparam int FLAT_W          = WORDS_PER_FRAME * TX_W;

    typedef struct packed {
        logic [GID_W-1:0]   gid;
        logic [LABEL_W-1:0] t01;
        logic [LABEL_W-1:0] t10;
        logic [LABEL_W-1:0] t11;
    } gc_frame_t;

    localparam int PAD_W = FLAT_W - $bits(gc_frame_t);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_t;

    // Word 0 is the most significant 32 bits of {frame, zero pad}.
    function automatic logic [TX_W-1:0] frame_word(input gc_frame_t f, input logic [3:0] idx);
        logic [FLAT_W-1:0] flat;
        flat = {f, {PAD_W{1'b0}}};
        if (int'(idx) >= WORDS_PER_FRAME)
            return '0;
        return flat[FLAT_W-1 - int'(idx)*TX_W -: TX_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/gc_frame_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gc_frame_fifo : show-ahead synchronous FIFO of gc_frame_t; a push while
//                 full is accepted when a pop happens in the same cycle. rev 1.0
// ---------------------------------------------------------------------------
module gc_frame_fifo
    import gc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push,
    input  gc_frame_t wr_data,
    input  logic      pop,
    output gc_frame_t rd_data,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    gc_frame_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/gc_table_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gc_table_serializer : captures evaluator gate results, writes Gc to label
//                       memory and streams {gid,t01,t10,t11} as 10 words. rev 1.0
// ---------------------------------------------------------------------------
module gc_table_serializer
    import gc_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic [GID_W-1:0]   in_gid,
    input  logic [LABEL_W-1:0] in_gc,
    input  logic [LABEL_W-1:0] in_t01,
    input  logic [LABEL_W-1:0] in_t10,
    input  logic [LABEL_W-1:0] in_t11,
    output logic               gc_we,
    output logic [ADDR_W-1:0]  gc_addr,
    output logic [LABEL_W-1:0] gc_data,
    output logic [TX_W-1:0]    tx_data,
    output logic               tx_valid,
    output logic               tx_last,
    input  logic               tx_ready,
    output logic               fifo_full,
    output logic               overflow,
    input  logic               clr_overflow,
    output logic [31:0]        frame_cnt
);

    localparam logic [3:0] LAST_IDX = 4'(WORDS_PER_FRAME - 1);

    logic       in_valid_q;
    logic       capture;
    gc_frame_t  cap_frame;
    gc_frame_t  fifo_rd;
    logic       fifo_empty;
    logic       push_req;
    logic       push_ok;
    logic       drop;

    ser_state_t state, state_d;
    logic [3:0] idx, idx_d;
    gc_frame_t  frame;
    logic       load_fifo;
    logic       load_bypass;
    logic       hs;
    logic       last_hs;

    assign capture = in_valid & ~in_valid_q;

    // gc_we doubles as the "captured frame is on offer" strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_valid_q <= 1'b0;
            gc_we      <= 1'b0;
            gc_addr    <= '0;
            gc_data    <= '0;
            cap_frame  <= '0;
        end else begin
            in_valid_q <= in_valid;
            gc_we      <= capture;
            if (capture) begin
                gc_addr   <= in_gid[ADDR_W-1:0];
                gc_data   <= in_gc;
                cap_frame <= '{gid: in_gid, t01: in_t01, t10: in_t10, t11: in_t11};
            end
        end
    end

    // When idle with an empty FIFO the offered frame goes straight to the
    // frame register, giving the two-cycle capture-to-valid latency.
    assign push_req = gc_we & ~load_bypass;
    assign push_ok  = push_req & (~fifo_full | load_fifo);
    assign drop     = push_req & ~push_ok;

    gc_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_req),
        .wr_data (cap_frame),
        .pop     (load_fifo),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign tx_valid = (state == S_SEND);
    assign hs       = tx_valid & tx_ready;
    assign last_hs  = hs & (idx == LAST_IDX);
    assign tx_last  = tx_valid & (idx == LAST_IDX);
    assign tx_data  = frame_word(frame, idx);

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        load_fifo   = 1'b0;
        load_bypass = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    load_fifo = 1'b1;
                    state_d   = S_SEND;
                    idx_d     = '0;
                end else if (gc_we) begin
                    load_bypass = 1'b1;
                    state_d     = S_SEND;
                    idx_d       = '0;
                end
            end
            S_SEND: begin
                if (last_hs) begin
                    idx_d = '0;
                    if (!fifo_empty)
                        load_fifo = 1'b1;
                    else
                        state_d = S_IDLE;
                end else if (hs) begin
                    idx_d = idx + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            frame     <= '0;
            frame_cnt <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            if (load_fifo)
                frame <= fifo_rd;
            else if (load_bypass)
                frame <= cap_frame;
            if (last_hs)
                frame_cnt <= frame_cnt + 32'd1;
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (clr_overflow)
            overflow <= 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_gc_table_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gc_table_serializer : directed + randomized bench with a queue-based
//                          frame/label reference model.   rev 1.0
// ---------------------------------------------------------------------------
module tb_gc_table_serializer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 16;

    typedef logic [319:0] flat_t;
    typedef logic [95:0]  we_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic [63:0]  in_gid;
    logic [79:0]  in_gc, in_t01, in_t10, in_t11;
    logic         gc_we;
    logic [15:0]  gc_addr;
    logic [79:0]  gc_data;
    logic [31:0]  tx_data;
    logic         tx_valid, tx_last, tx_ready;
    logic         fifo_full, overflow, clr_overflow;
    logic [31:0]  frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    flat_t exp_q[$];
    we_t   we_q[$];
    int    mon_idx = 0;
    int    done_frames = 0;
    int    hs_cnt = 0;
    int    we_cnt = 0;
    int    ready_mode = 0;
    bit    stalled = 1'b0;
    logic [31:0] held_data;
    logic        held_last;

    always #5 clk = ~clk;

    gc_table_serializer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_gid       (in_gid),
        .in_gc        (in_gc),
        .in_t01       (in_t01),
        .in_t10       (in_t10),
        .in_t11       (in_t11),
        .gc_we        (gc_we),
        .gc_addr      (gc_addr),
        .gc_data      (gc_data),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_last      (tx_last),
        .tx_ready     (tx_ready),
        .fifo_full    (fifo_full),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .frame_cnt    (frame_cnt)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] rnd80();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[79:0];
    endfunction

    // Every stimulus cycle passes through here: inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ready_mode == 1)
            tx_ready = ~tx_ready;
        else if (ready_mode == 2)
            tx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic expect_gate(input logic [63:0] gid, input logic [79:0] gc, input logic [79:0] t01,
                               input logic [79:0] t10, input logic [79:0] t11, input bit drop);
        in_gid = gid; in_gc = gc; in_t01 = t01; in_t10 = t10; in_t11 = t11;
        if (!drop)
            exp_q.push_back({gid, t01, t10, t11, 16'h0000});
        we_q.push_back({gid[ADDR_W-1:0], gc});
        in_valid = 1'b1;
    endtask

    task automatic drive_gate(input logic [63:0] gid, input logic [79:0] gc, input logic [79:0] t01,
                              input logic [79:0] t10, input logic [79:0] t11, input int hold, input bit drop);
        expect_gate(gid, gc, t01, t10, t11, drop);
        repeat (hold) tick();
        in_valid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic drive_rand(input int hold, input bit drop);
        drive_gate({$urandom(), $urandom()}, rnd80(), rnd80(), rnd80(), rnd80(), hold, drop);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || we_q.size() != 0 || tx_valid) && n < 3000) begin
            tick();
            n++;
        end
        check_eq("idle_timeout", 128'(n < 3000), 128'(1));
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_gc_we"},     128'(gc_we),     128'(0));
        check_eq({tag, "_tx_valid"},  128'(tx_valid),  128'(0));
        check_eq({tag, "_tx_last"},   128'(tx_last),   128'(0));
        check_eq({tag, "_fifo_full"}, 128'(fifo_full), 128'(0));
        check_eq({tag, "_overflow"},  128'(overflow),  128'(0));
        check_eq({tag, "_gc_addr"},   128'(gc_addr),   128'(0));
        check_eq({tag, "_gc_data"},   128'(gc_data),   128'(0));
        check_eq({tag, "_tx_data"},   128'(tx_data),   128'(0));
        check_eq({tag, "_frame_cnt"}, 128'(frame_cnt), 128'(0));
    endtask

    // Monitor: label writes and stream words against the reference queues.
    always @(negedge clk) begin
        if (reset_n) begin
            if (gc_we) begin
                we_cnt++;
                if (we_q.size() == 0) begin
                    check_eq("gc_we_unexpected", 128'(gc_we), 128'(0));
                end else begin
                    we_t e;
                    e = we_q.pop_front();
                    check_eq("gc_addr", 128'(gc_addr), 128'(e[95:80]));
                    check_eq("gc_data", 128'(gc_data), 128'(e[79:0]));
                end
            end
            if (stalled) begin
                check_eq("hold_valid", 128'(tx_valid), 128'(1));
                check_eq("hold_data",  128'(tx_data),  128'(held_data));
                check_eq("hold_last",  128'(tx_last),  128'(held_last));
            end
            if (!tx_valid) begin
                check_eq("idle_last", 128'(tx_last), 128'(0));
            end else if (exp_q.size() == 0) begin
                check_eq("tx_unexpected", 128'(tx_valid), 128'(0));
            end else begin
                flat_t f;
                logic [31:0] w;
                f = exp_q[0];
                w = f[319 - 32*mon_idx -: 32];
                check_eq("tx_word", 128'(tx_data), 128'(w));
                check_eq("tx_last", 128'(tx_last), 128'(mon_idx == 9));
                if (tx_ready) begin
                    hs_cnt++;
                    if (mon_idx == 9) begin
                        void'(exp_q.pop_front());
                        mon_idx = 0;
                        done_frames++;
                    end else begin
                        mon_idx++;
                    end
                end
            end
            stalled   = tx_valid & ~tx_ready;
            held_data = tx_data;
            held_last = tx_last;
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        int hs0;
        int we0;
        int cnt;
        int n;
        int sent;

        reset_n = 1'b0; in_valid = 1'b0; tx_ready = 1'b0; clr_overflow = 1'b0;
        in_gid = '0; in_gc = '0; in_t01 = '0; in_t10 = '0; in_t11 = '0;
        repeat (3) tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Single gate, in_valid held 5 cycles, latency check.
        tx_ready = 1'b1;
        expect_gate(64'h0000_0001_0000_0005, 80'hABCD_EF01_2345_6789_AAAA,
                    80'h1111_2222_3333_4444_5555, 80'h6666_7777_8888_9999_AAAA,
                    80'hBBBB_CCCC_DDDD_EEEE_FFFF, 1'b0);
        @(negedge clk);
        check_eq("lat_we_n", 128'(gc_we), 128'(0));
        @(negedge clk);
        check_eq("lat_we_n1", 128'(gc_we), 128'(1));
        check_eq("lat_valid_n1", 128'(tx_valid), 128'(0));
        @(negedge clk);
        check_eq("lat_valid_n2", 128'(tx_valid), 128'(1));
        @(posedge clk); #1;
        tick(); tick();
        in_valid = 1'b0;
        wait_idle();
        check_eq("single_frame_cnt", 128'(frame_cnt), 128'(1));
        check_eq("single_words", 128'(hs_cnt), 128'(10));
        check_eq("single_we", 128'(we_cnt), 128'(1));

        // Back-pressure with alternating ready.
        hs0 = hs_cnt;
        ready_mode = 1;
        drive_rand(2, 1'b0);
        wait_idle();
        ready_mode = 0;
        check_eq("bp_words", 128'(hs_cnt - hs0), 128'(10));
        check_eq("bp_frame_cnt", 128'(frame_cnt), 128'(2));

        // Overflow: 5 held (1 frame reg + 4 FIFO), 6th dropped.
        tx_ready = 1'b0;
        we0 = we_cnt;
        for (int i = 0; i < 6; i++)
            drive_rand(2, i == 5);
        check_eq("ovf_flag", 128'(overflow), 128'(1));
        check_eq("ovf_full", 128'(fifo_full), 128'(1));
        check_eq("ovf_we_count", 128'(we_cnt - we0), 128'(6));
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check_eq("ovf_clear", 128'(overflow), 128'(0));
        // A drop coinciding with a clear must leave the flag set.
        expect_gate({$urandom(), $urandom()}, rnd80(), rnd80(), rnd80(), rnd80(), 1'b1);
        tick();
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        in_valid = 1'b0;
        check_eq("ovf_set_wins", 128'(overflow), 128'(1));
        tick();
        tx_ready = 1'b1;
        wait_idle();
        check_eq("ovf_frame_cnt", 128'(frame_cnt), 128'(7));
        check_eq("ovf_sticky", 128'(overflow), 128'(1));
        check_eq("ovf_drained", 128'(fifo_full), 128'(0));

        // Full FIFO with a push landing on the w9 handshake.
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            drive_rand(1, 1'b0);
        check_eq("fp_full", 128'(fifo_full), 128'(1));
        tx_ready = 1'b1;
        repeat (8) tick();
        expect_gate({$urandom(), $urandom()}, rnd80(), rnd80(), rnd80(), rnd80(), 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_eq("fp_coincide_we", 128'(gc_we), 128'(1));
        check_eq("fp_coincide_last", 128'(tx_last), 128'(1));
        check_eq("fp_coincide_full", 128'(fifo_full), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_idle();
        check_eq("fp_overflow", 128'(overflow), 128'(0));
        check_eq("fp_frame_cnt", 128'(frame_cnt), 128'(13));

        // Back-to-back: three queued frames stream with no bubble.
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            drive_rand(1, 1'b0);
        repeat (2) tick();
        tx_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_valid) cnt++;
        end
        check_eq("b2b_valid_cycles", 128'(cnt), 128'(30));
        @(negedge clk);
        check_eq("b2b_end", 128'(tx_valid), 128'(0));
        @(posedge clk); #1;
        wait_idle();
        check_eq("b2b_frame_cnt", 128'(frame_cnt), 128'(16));

        // Reset while word 4 is on the bus.
        tx_ready = 1'b1;
        expect_gate({$urandom(), $urandom()}, rnd80(), rnd80(), rnd80(), rnd80(), 1'b0);
        n = 0;
        while (mon_idx != 4 && n < 50) begin
            tick();
            n++;
        end
        check_eq("rst_reach_w4", 128'(n < 50), 128'(1));
        reset_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check_all_zero("rst_mid");
        exp_q.delete();
        we_q.delete();
        mon_idx = 0;
        done_frames = 0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        drive_rand(3, 1'b0);
        wait_idle();
        check_eq("rst_new_frame_cnt", 128'(frame_cnt), 128'(1));

        // Randomized gates and random ready, never exceeding buffering capacity.
        ready_mode = 2;
        sent = 1;
        for (int g = 0; g < 24; g++) begin
            n = 0;
            while (exp_q.size() >= DEPTH && n < 500) begin
                tick();
                n++;
            end
            check_eq("rand_space_timeout", 128'(n < 500), 128'(1));
            drive_rand($urandom_range(1, 4), 1'b0);
            sent++;
        end
        ready_mode = 0;
        tx_ready = 1'b1;
        wait_idle();
        check_eq("rand_frame_cnt", 128'(frame_cnt), 128'(sent));
        check_eq("rand_model_frames", 128'(done_frames), 128'(sent));
        check_eq("rand_overflow", 128'(overflow), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
